// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter (fetch vs load/store) for a single-port synchronous word memory.
// Optional build macro: ARB_STATS_EN adds a saturating conflict_cnt output.
module imem_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF    = 2'd1,
    OWN_LOAD  = 2'd2,
    OWN_STORE = 2'd3
  } owner_t;

  owner_t            owner_q, owner_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;
  logic [DATA_W-1:0] ls_hold_q, ls_hold_d;
  logic              force_if;

  // Grant and memory-port mux; everything is held off while reset is asserted.
  always_comb begin
    force_if  = (wait_cnt_q == 4'(MAX_WAIT));
    if_gnt    = rst_n && if_req && (!ls_req || force_if);
    ls_gnt    = rst_n && ls_req && !if_gnt;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  // Responses come straight from the owner register so read data lines up with mem_rdata.
  always_comb begin
    if_rvalid = rst_n && (owner_q == OWN_IF);
    ls_rvalid = rst_n && ((owner_q == OWN_LOAD) || (owner_q == OWN_STORE));
    if_rdata  = if_rvalid ? mem_rdata : if_hold_q;
    if (ls_rvalid) begin
      ls_rdata = (owner_q == OWN_LOAD) ? mem_rdata : '0;
    end else begin
      ls_rdata = ls_hold_q;
    end
    if_hold_d = if_rdata;
    ls_hold_d = ls_rdata;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ls_gnt) begin
      owner_d = ls_we ? OWN_STORE : OWN_LOAD;
    end
    wait_cnt_d = wait_cnt_q;
    if (!if_req || if_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < 4'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      wait_cnt_q <= 4'd0;
      if_hold_q  <= '0;
      ls_hold_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      if_hold_q  <= if_hold_d;
      ls_hold_q  <= ls_hold_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Counts raw request overlap, independent of who wins.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (if_req && ls_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: memory model, behavioural arbiter model, directed vectors.
// With ARB_STATS_EN defined the conflict counter is checked as well.
module tb_imem_port_arbiter;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we;
  logic [4:0]  if_addr, ls_addr;
  logic [31:0] ls_wdata;
  logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_wdata;
  logic [4:0]  mem_addr;
  logic [31:0] mem_rdata = 32'd0;
`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 3) return 32'h009462b3;
    return 32'hA5A50000 | (i * 32'h111);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    $display("txn %s got=%h exp=%h", name, got, exp);
    chk(name, got, exp);
  endtask

  // Memory array attached to the DUT port; mem_rdata is scrambled whenever no read is issued.
  logic [31:0] pmem [32];
  logic        pmem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!pmem_loaded) begin
      for (int i = 0; i < 32; i++) pmem[i] <= init_word(i);
      pmem_loaded <= 1'b1;
      mem_rdata   <= $urandom;
    end else if (mem_en && !mem_we) begin
      mem_rdata <= pmem[mem_addr];
    end else begin
      if (mem_en) pmem[mem_addr] <= mem_wdata;
      mem_rdata <= $urandom;
    end
  end

  // Behavioural model: golden memory, refusal count, and the one pending response.
  logic [31:0] gm [32];
  logic        gm_loaded = 1'b0;
  logic        m_live = 1'b0;
  int          m_denied = 0;
  int          m_pend = 0;          // 0 none, 1 fetch, 2 load, 3 store
  logic [31:0] m_pend_data = 32'd0;
  logic [31:0] m_if_hold = 32'd0, m_ls_hold = 32'd0;
  logic [15:0] m_conf = 16'd0;

  logic        e_if_gnt, e_ls_gnt, e_mem_en, e_mem_we, e_if_rv, e_ls_rv;
  logic [4:0]  e_addr;
  logic [31:0] e_wdata, e_if_rdata, e_ls_rdata;

  always_comb begin
    e_if_gnt = 1'b0;
    e_ls_gnt = 1'b0;
    if (rst_n) begin
      if (if_req && ls_req) begin
        if (m_denied == MAX_WAIT) e_if_gnt = 1'b1;
        else e_ls_gnt = 1'b1;
      end else begin
        e_if_gnt = if_req;
        e_ls_gnt = ls_req;
      end
    end
    e_mem_en   = e_if_gnt || e_ls_gnt;
    e_mem_we   = e_ls_gnt && ls_we;
    e_addr     = e_ls_gnt ? ls_addr : (e_if_gnt ? if_addr : 5'd0);
    e_wdata    = e_ls_gnt ? ls_wdata : 32'd0;
    e_if_rv    = rst_n && (m_pend == 1);
    e_ls_rv    = rst_n && (m_pend >= 2);
    e_if_rdata = e_if_rv ? m_pend_data : m_if_hold;
    e_ls_rdata = e_ls_rv ? ((m_pend == 2) ? m_pend_data : 32'd0) : m_ls_hold;
  end

  always @(posedge clk) begin
    if (!gm_loaded) begin
      for (int i = 0; i < 32; i++) gm[i] <= init_word(i);
      gm_loaded <= 1'b1;
    end
    if (!rst_n) begin
      m_live    <= 1'b1;
      m_denied  <= 0;
      m_pend    <= 0;
      m_if_hold <= 32'd0;
      m_ls_hold <= 32'd0;
      m_conf    <= 16'd0;
    end else begin
      m_if_hold <= e_if_rdata;
      m_ls_hold <= e_ls_rdata;
      m_denied  <= (if_req && !e_if_gnt) ? m_denied + 1 : 0;
      if (if_req && ls_req && m_conf != 16'hFFFF) m_conf <= m_conf + 16'd1;
      if (e_if_gnt) begin
        m_pend      <= 1;
        m_pend_data <= gm[if_addr];
      end else if (e_ls_gnt) begin
        m_pend      <= ls_we ? 3 : 2;
        m_pend_data <= gm[ls_addr];
        if (ls_we) gm[ls_addr] <= ls_wdata;
      end else begin
        m_pend <= 0;
      end
    end
  end

  // Per-cycle comparison on the falling edge once the first reset edge has been seen.
  always @(negedge clk) begin
    if (m_live) begin
      chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
      chk("ls_gnt", 32'(ls_gnt), 32'(e_ls_gnt));
      chk("mem_en", 32'(mem_en), 32'(e_mem_en));
      chk("mem_we", 32'(mem_we), 32'(e_mem_we));
      if (e_mem_en || (!if_req && !ls_req)) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_ls_gnt || (!if_req && !ls_req)) chk("mem_wdata", mem_wdata, e_wdata);
      chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("ls_rvalid", 32'(ls_rvalid), 32'(e_ls_rv));
      chk("ls_rdata", ls_rdata, e_ls_rdata);
`ifdef ARB_STATS_EN
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
    end
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    if_addr = 5'd3; ls_addr = 5'd2; ls_wdata = 32'd0;

    // Reset hold with both requesters active
    repeat (3) @(negedge clk);
    lit("rst_if_gnt", 32'(if_gnt), 32'd0);
    lit("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    lit("rst_mem_en", 32'(mem_en), 32'd0);
    lit("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
    lit("rst_if_rdata", if_rdata, 32'd0);
    lit("rst_ls_rdata", ls_rdata, 32'd0);

    @(posedge clk); #1; rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk); lit("idle_mem_en", 32'(mem_en), 32'd0);

    // Fetch only
    @(posedge clk); #1; if_req = 1'b1; if_addr = 5'd3;
    @(negedge clk); lit("fetch_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk); lit("fetch_rvalid", 32'(if_rvalid), 32'd1);
    lit("fetch_rdata", if_rdata, 32'h009462b3);

    // Store then load to the same word
    @(posedge clk); #1; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 5'd2; ls_wdata = 32'h10;
    @(negedge clk); lit("store_mem_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1; ls_we = 1'b0;
    @(negedge clk); lit("store_ack", 32'(ls_rvalid), 32'd1);
    lit("store_rdata", ls_rdata, 32'd0);
    lit("load_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1; ls_req = 1'b0;
    @(negedge clk); lit("load_rdata", ls_rdata, 32'h10);
    lit("load_hold_mem_en", 32'(mem_en), 32'd0);

    // Continuous contention: L, L, I repeating
    @(posedge clk); #1; if_req = 1'b1; if_addr = 5'd7; ls_req = 1'b1; ls_addr = 5'd9;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); lit($sformatf("contend_%0d_ls", k), 32'(ls_gnt), 32'((k % 3) != 2));
      @(posedge clk); #1;
    end
    if_req = 1'b0; ls_req = 1'b0;

    // Top address: store and fetch collide, fetch then sees new data; then address 0
    @(posedge clk); #1; if_req = 1'b1; if_addr = 5'd31;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 5'd31; ls_wdata = 32'hDEADBEEF;
    @(negedge clk); lit("top_store_gnt", 32'(ls_gnt), 32'd1);
    lit("top_mem_addr", 32'(mem_addr), 32'd31);
    @(posedge clk); #1; ls_req = 1'b0; ls_we = 1'b0;
    @(negedge clk); lit("top_fetch_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #1; if_addr = 5'd0;
    @(negedge clk); lit("top_fetch_rdata", if_rdata, 32'hDEADBEEF);
    lit("zero_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk); lit("zero_fetch_rdata", if_rdata, 32'hA5A50000);

    // Reset in the cycle after a load grant drops the response
    @(posedge clk); #1; ls_req = 1'b1; ls_addr = 5'd2;
    @(negedge clk); lit("mid_load_gnt", 32'(ls_gnt), 32'd1);
    @(posedge clk); #1; ls_req = 1'b0; rst_n = 1'b0;
    @(negedge clk); lit("mid_rst_rvalid", 32'(ls_rvalid), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; if_req = 1'b1; if_addr = 5'd3;
    @(negedge clk); lit("post_rst_gnt", 32'(if_gnt), 32'd1);
    lit("post_rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk); lit("post_rst_rdata", if_rdata, 32'h009462b3);

    // Random traffic with occasional reset, checked by the model
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      rst_n    = ($urandom_range(0, 39) != 0);
      if_req   = 1'($urandom);
      ls_req   = 1'($urandom);
      ls_we    = 1'($urandom);
      if_addr  = 5'($urandom);
      ls_addr  = 5'($urandom);
      ls_wdata = $urandom;
    end
    @(posedge clk); #1; rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    repeat (2) @(posedge clk);

`ifdef ARB_STATS_EN
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    repeat (5) @(posedge clk);
    #1; if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk); lit("conflict_5", 32'(conflict_cnt), 32'd5);
    @(posedge clk); #1; if_req = 1'b1; ls_req = 1'b1;
    repeat (65535) @(posedge clk);
    #1; if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk); lit("conflict_sat", 32'(conflict_cnt), 32'h0000FFFF);
`endif

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
